// File: rtl/n64_vdemux.sv
// N64 multiplexed video bus demultiplexer: sync byte + R/G/B per 4 VCLK,
// with 16-bit colour reduction, de-blur pixel hold and bus lock tracking.
module n64_vdemux (
  input  logic       VCLK,
  input  logic       nRST,
  input  logic       nDSYNC,
  input  logic [6:0] D_i,
  input  logic       n64_480i,
  input  logic       n16bit_mode,
  input  logic       nDeBlur,
  output logic [3:0] S_o,
  output logic [6:0] R_o,
  output logic [6:0] G_o,
  output logic [6:0] B_o,
  output logic       PX_VALID,
  output logic       LOCKED
);

  typedef enum logic [1:0] {ST_IDLE, ST_R, ST_G, ST_B} state_t;

  state_t     state_q, state_d;
  logic       wrap_q, wrap_d;
  logic [3:0] sync_q, sync_d;
  logic [6:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic       pend_q, pend_d;
  logic [1:0] cnt_q, cnt_d;
  logic       lock_q, lock_d;

  logic [3:0] s_q, s_d;
  logic [6:0] ro_q, ro_d, go_q, go_d, bo_q, bo_d;
  logic       pv_q, pv_d;
  logic       odd_q, odd_d;

  logic [1:0] m16_q, mdb_q, m480_q;

  logic good, err;
  logic hs_fall, eff_odd, hold;

  // ST_IDLE with wrap_q set is the wrap point right after a complete pixel,
  // where a missing sync byte counts as a bus error.
  always_comb begin
    state_d = state_q;
    wrap_d  = 1'b0;
    sync_d  = sync_q;
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
    pend_d  = 1'b0;
    good    = 1'b0;
    err     = 1'b0;
    if (!nDSYNC) begin
      sync_d  = D_i[3:0];
      state_d = ST_R;
      if (state_q == ST_IDLE) good = wrap_q;
      else                    err  = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: err = wrap_q;
        ST_R: begin
          r_d     = D_i;
          state_d = ST_G;
        end
        ST_G: begin
          g_d     = D_i;
          state_d = ST_B;
        end
        ST_B: begin
          b_d     = D_i;
          pend_d  = 1'b1;
          wrap_d  = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    lock_d = lock_q;
    if (err) begin
      cnt_d  = '0;
      lock_d = 1'b0;
    end else if (good) begin
      if (cnt_q == 2'd3) lock_d = 1'b1;
      else               cnt_d  = cnt_q + 2'd1;
    end
  end

  // A pixel that starts a line (nHSYNC falling) is forced even.
  assign hs_fall = s_q[1] & ~sync_q[1];
  assign eff_odd = odd_q & ~hs_fall;
  assign hold    = ~mdb_q[1] & ~m480_q[1] & eff_odd;

  always_comb begin
    s_d   = s_q;
    ro_d  = ro_q;
    go_d  = go_q;
    bo_d  = bo_q;
    odd_d = odd_q;
    pv_d  = pend_q;
    if (pend_q) begin
      s_d   = sync_q;
      odd_d = ~eff_odd;
      if (!hold) begin
        ro_d = {r_q[6:2], r_q[1:0] & {2{m16_q[1]}}};
        go_d = {g_q[6:2], g_q[1:0] & {2{m16_q[1]}}};
        bo_d = {b_q[6:2], b_q[1:0] & {2{m16_q[1]}}};
      end
    end
  end

  always_ff @(posedge VCLK) begin
    if (!nRST) begin
      state_q <= ST_IDLE;
      wrap_q  <= 1'b0;
      sync_q  <= '1;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      lock_q  <= 1'b0;
      s_q     <= '1;
      ro_q    <= '0;
      go_q    <= '0;
      bo_q    <= '0;
      pv_q    <= 1'b0;
      odd_q   <= 1'b0;
      m16_q   <= '1;
      mdb_q   <= '1;
      m480_q  <= '1;
    end else begin
      state_q <= state_d;
      wrap_q  <= wrap_d;
      sync_q  <= sync_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      lock_q  <= lock_d;
      s_q     <= s_d;
      ro_q    <= ro_d;
      go_q    <= go_d;
      bo_q    <= bo_d;
      pv_q    <= pv_d;
      odd_q   <= odd_d;
      m16_q   <= {m16_q[0], n16bit_mode};
      mdb_q   <= {mdb_q[0], nDeBlur};
      m480_q  <= {m480_q[0], n64_480i};
    end
  end

  assign S_o      = s_q;
  assign R_o      = ro_q;
  assign G_o      = go_q;
  assign B_o      = bo_q;
  assign PX_VALID = pv_q;
  assign LOCKED   = lock_q;

endmodule

// File: tb/tb_n64_vdemux.sv
// Scoreboard bench for n64_vdemux: directed pixel streams with hand-computed
// expected outputs, checked by a monitor on every PX_VALID pulse.
`timescale 1ns/1ps
module tb_n64_vdemux;

  logic       VCLK = 1'b0;
  logic       nRST = 1'b0;
  logic       nDSYNC = 1'b1;
  logic [6:0] D_i = '0;
  logic       n64_480i = 1'b0;
  logic       n16bit_mode = 1'b1;
  logic       nDeBlur = 1'b1;
  logic [3:0] S_o;
  logic [6:0] R_o, G_o, B_o;
  logic       PX_VALID, LOCKED;

  typedef struct packed {
    logic       b2b;
    logic [3:0] s;
    logic [6:0] r;
    logic [6:0] g;
    logic [6:0] b;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          pv_seen = 0;
  int          pv_exp = 0;
  int unsigned cyc = 0;
  int unsigned last_pv = 0;

  always #10 VCLK = ~VCLK;

  n64_vdemux dut (
    .VCLK       (VCLK),
    .nRST       (nRST),
    .nDSYNC     (nDSYNC),
    .D_i        (D_i),
    .n64_480i   (n64_480i),
    .n16bit_mode(n16bit_mode),
    .nDeBlur    (nDeBlur),
    .S_o        (S_o),
    .R_o        (R_o),
    .G_o        (G_o),
    .B_o        (B_o),
    .PX_VALID   (PX_VALID),
    .LOCKED     (LOCKED)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] s, input logic [6:0] r, input logic [6:0] g,
                              input logic [6:0] b, input logic b2b);
    exp_t e;
    e.b2b = b2b;
    e.s   = s;
    e.r   = r;
    e.g   = g;
    e.b   = b;
    return e;
  endfunction

  // Monitor: pops one expectation per PX_VALID pulse.
  always @(negedge VCLK) begin
    cyc++;
    if (PX_VALID === 1'b1) begin
      pv_seen++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_px_valid: got S=%0h R=%0h G=%0h B=%0h, required no pulse (t=%0t)",
                 S_o, R_o, G_o, B_o, $time);
      end else begin
        mon_e = sb.pop_front();
        check("S_o", 32'(S_o), 32'(mon_e.s));
        check("R_o", 32'(R_o), 32'(mon_e.r));
        check("G_o", 32'(G_o), 32'(mon_e.g));
        check("B_o", 32'(B_o), 32'(mon_e.b));
        if (mon_e.b2b) check("px_spacing", cyc - last_pv, 32'd4);
      end
      last_pv = cyc;
    end
  end

  task automatic send_byte(input logic ns, input logic [6:0] d);
    nDSYNC = ns;
    D_i    = d;
    @(posedge VCLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) send_byte(1'b1, 7'h00);
  endtask

  // lk < 0: no lock check; otherwise LOCKED is checked right after the sync byte edge.
  task automatic send_pixel(input logic [3:0] s, input logic [6:0] r, input logic [6:0] g,
                            input logic [6:0] b, input exp_t e, input int lk);
    send_byte(1'b0, {3'b000, s});
    if (lk >= 0) check("LOCKED", 32'(LOCKED), 32'(lk));
    send_byte(1'b1, r);
    send_byte(1'b1, g);
    sb.push_back(e);
    pv_exp++;
    send_byte(1'b1, b);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    // Reset state
    repeat (3) @(posedge VCLK);
    #1;
    check("rst_S_o", 32'(S_o), 32'hF);
    check("rst_R_o", 32'(R_o), 32'h0);
    check("rst_G_o", 32'(G_o), 32'h0);
    check("rst_B_o", 32'(B_o), 32'h0);
    check("rst_PX_VALID", 32'(PX_VALID), 32'h0);
    check("rst_LOCKED", 32'(LOCKED), 32'h0);
    nRST = 1'b1;
    idle(2);

    // Clean stream of 6 pixels; 4th good wrap is the sync of pixel 5
    for (int i = 0; i < 6; i++)
      send_pixel(4'hF, 7'h55, 7'h2A, 7'h7F, mk(4'hF, 7'h55, 7'h2A, 7'h7F, i > 0),
                 (i == 3) ? 0 : (i >= 4) ? 1 : -1);
    // Missing sync at wrap
    send_byte(1'b1, 7'h00);
    check("LOCKED_missing", 32'(LOCKED), 32'h0);
    idle(3);

    // 16-bit colour reduction
    n16bit_mode = 1'b0;
    idle(3);
    send_pixel(4'hF, 7'h57, 7'h2A, 7'h7F, mk(4'hF, 7'h54, 7'h28, 7'h7C, 1'b0), -1);
    n16bit_mode = 1'b1;
    idle(3);

    // De-blur active: nHSYNC falls on pixel 0, odd pixels hold
    nDeBlur  = 1'b0;
    n64_480i = 1'b0;
    idle(3);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0)
        send_pixel(4'hD, 7'h10, 7'h11, 7'h12, mk(4'hD, 7'h10, 7'h11, 7'h12, i > 0), -1);
      else
        send_pixel(4'hD, 7'h20, 7'h21, 7'h22, mk(4'hD, 7'h10, 7'h11, 7'h12, 1'b1), -1);
    end
    // 480i forces de-blur off
    n64_480i = 1'b1;
    idle(3);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0)
        send_pixel(4'hD, 7'h10, 7'h11, 7'h12, mk(4'hD, 7'h10, 7'h11, 7'h12, i > 0), -1);
      else
        send_pixel(4'hD, 7'h20, 7'h21, 7'h22, mk(4'hD, 7'h20, 7'h21, 7'h22, 1'b1), -1);
    end
    nDeBlur  = 1'b1;
    n64_480i = 1'b0;
    idle(3);

    // Early sync during G phase
    for (int i = 0; i < 5; i++)
      send_pixel(4'hF, 7'h55, 7'h2A, 7'h7F, mk(4'hF, 7'h55, 7'h2A, 7'h7F, i > 0),
                 (i == 4) ? 1 : -1);
    send_byte(1'b0, 7'h0F);
    send_byte(1'b1, 7'h33);
    send_pixel(4'hF, 7'h11, 7'h22, 7'h33, mk(4'hF, 7'h11, 7'h22, 7'h33, 1'b0), 0);
    send_pixel(4'hF, 7'h55, 7'h2A, 7'h7F, mk(4'hF, 7'h55, 7'h2A, 7'h7F, 1'b1), 0);

    // Missing sync, then relock after 4 good pixels
    send_byte(1'b1, 7'h00);
    check("LOCKED_missing2", 32'(LOCKED), 32'h0);
    idle(3);
    for (int i = 0; i < 6; i++)
      send_pixel(4'hF, 7'h55, 7'h2A, 7'h7F, mk(4'hF, 7'h55, 7'h2A, 7'h7F, i > 0),
                 (i == 3) ? 0 : (i >= 4) ? 1 : -1);

    // Reset mid-pixel (after R)
    send_byte(1'b0, 7'h0F);
    send_byte(1'b1, 7'h44);
    nRST = 1'b0;
    send_byte(1'b1, 7'h55);
    check("midrst_S_o", 32'(S_o), 32'hF);
    check("midrst_R_o", 32'(R_o), 32'h0);
    check("midrst_G_o", 32'(G_o), 32'h0);
    check("midrst_B_o", 32'(B_o), 32'h0);
    check("midrst_PX_VALID", 32'(PX_VALID), 32'h0);
    check("midrst_LOCKED", 32'(LOCKED), 32'h0);
    nRST = 1'b1;
    idle(2);
    send_pixel(4'h9, 7'h12, 7'h34, 7'h56, mk(4'h9, 7'h12, 7'h34, 7'h56, 1'b0), -1);
    idle(4);

    k = 0;
    while (sb.size() != 0 && k < 50) begin
      idle(1);
      k++;
    end
    check("sb_drained", 32'(sb.size()), 32'h0);
    check("px_count", 32'(pv_seen), 32'(pv_exp));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
